// File: rtl/cmp_flags_seq.sv
// Multi-cycle NZCV compare-flags unit: evaluates CMP/CMN/TST/TEQ over a
// registered ripple carry, CHUNK bits per cycle, with valid/ready on both sides.
module cmp_flags_seq #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             n,
    output logic             z,
    output logic             c,
    output logic             v,
    output logic [WIDTH-1:0] res
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] work_reg;
    logic [1:0]       op_reg;
    logic [IW-1:0]    idx;
    logic             carry;
    logic             zero_acc;

    logic [CHUNK-1:0] a_c;
    logic [CHUNK-1:0] b_c;
    logic [CHUNK-1:0] b_eff;
    logic [CHUNK-1:0] chunk_res;
    logic [CHUNK:0]   sum;
    logic             carry_out;
    logic             carry_msb;
    logic [WIDTH-1:0] work_next;
    logic             accept;

    always_comb begin
        a_c       = a_reg[idx*CHUNK +: CHUNK];
        b_c       = b_reg[idx*CHUNK +: CHUNK];
        b_eff     = (op_reg == 2'b00) ? ~b_c : b_c;
        sum       = {1'b0, a_c} + {1'b0, b_eff} + {{CHUNK{1'b0}}, carry};
        carry_out = sum[CHUNK];
        // Carry into the chunk MSB recovered from the MSB sum bit and its addends.
        carry_msb = sum[CHUNK-1] ^ a_c[CHUNK-1] ^ b_eff[CHUNK-1];
        case (op_reg)
            2'b10:   chunk_res = a_c & b_c;
            2'b11:   chunk_res = a_c ^ b_c;
            default: chunk_res = sum[CHUNK-1:0];
        endcase
        work_next = work_reg;
        work_next[idx*CHUNK +: CHUNK] = chunk_res;
    end

    assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            work_reg  <= '0;
            op_reg    <= 2'b00;
            idx       <= '0;
            carry     <= 1'b0;
            zero_acc  <= 1'b0;
            out_valid <= 1'b0;
            n         <= 1'b0;
            z         <= 1'b0;
            c         <= 1'b0;
            v         <= 1'b0;
            res       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) state <= BUSY;
                end
                BUSY: begin
                    work_reg <= work_next;
                    carry    <= carry_out;
                    zero_acc <= zero_acc & (chunk_res == '0);
                    idx      <= idx + 1'b1;
                    if (idx == LAST) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        res       <= work_next;
                        n         <= work_next[WIDTH-1];
                        z         <= zero_acc & (chunk_res == '0);
                        // Logical ops leave C and V untouched.
                        if (!op_reg[1]) begin
                            c <= carry_out;
                            v <= carry_out ^ carry_msb;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= in_valid ? BUSY : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (accept) begin
                a_reg    <= a;
                b_reg    <= b;
                op_reg   <= op;
                idx      <= '0;
                carry    <= (op == 2'b00);
                zero_acc <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cmp_flags_seq.sv
// Scoreboard bench for cmp_flags_seq: directed 32/8 scenarios plus random
// sweeps of 16/4 and 8/8 instances against a behavioural flag model.
module tb_cmp_flags_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Main 32/8 instance
    logic        rst, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a, b, res;
    logic [1:0]  op;
    logic        n, z, c, v;
    logic [35:0] exp_q[$];

    cmp_flags_seq #(.WIDTH(32), .CHUNK(8)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .n(n), .z(z), .c(c), .v(v), .res(res)
    );

    task automatic start_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                            input logic [31:0] y, input logic [35:0] e);
        op = o; a = x; b = y; in_valid = 1'b1;
        #1;
        check_eq({tag, "/in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        a = $urandom; b = $urandom; op = 2'($urandom);
        exp_q.push_back(e);
    endtask

    task automatic wait_result(input string tag, input int lat);
        int cyc;
        logic [35:0] e;
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!out_valid && cyc < 40);
        check_eq({tag, "/latency"}, 64'(cyc), 64'(lat));
        check_eq({tag, "/queued"}, 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq({tag, "/result"}, 64'({res, n, z, c, v}), 64'(e));
        end
        $display("txn %s: res=%h nzcv=%b latency=%0d", tag, res, {n, z, c, v}, cyc);
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq({tag, "/drained"}, 64'(out_valid), 64'd0);
    endtask

    // Random parameter sweep instances
    for (genvar gi = 0; gi < 2; gi++) begin : g_sweep
        localparam int W  = (gi == 0) ? 16 : 8;
        localparam int C  = (gi == 0) ? 4 : 8;
        localparam int NC = W / C;

        logic         s_rst, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
        logic [W-1:0] s_a, s_b, s_res;
        logic [1:0]   s_op;
        logic         s_n, s_z, s_c, s_v;
        logic [W+3:0] s_q[$];
        logic         done = 1'b0;

        cmp_flags_seq #(.WIDTH(W), .CHUNK(C)) u_dut (
            .clk(clk), .rst(s_rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
            .a(s_a), .b(s_b), .op(s_op), .out_valid(s_out_valid), .out_ready(s_out_ready),
            .n(s_n), .z(s_z), .c(s_c), .v(s_v), .res(s_res)
        );

        initial begin
            logic         mc, mv;
            logic [W:0]   full;
            logic [W-1:0] r;
            logic [W+3:0] e;
            int           cyc;
            mc = 1'b0; mv = 1'b0;
            s_rst = 1'b1; s_in_valid = 1'b0; s_out_ready = 1'b0;
            s_a = '0; s_b = '0; s_op = 2'b00;
            repeat (2) @(posedge clk);
            #1 s_rst = 1'b0;
            for (int k = 0; k < 40; k++) begin
                s_a = W'($urandom); s_b = W'($urandom); s_op = 2'($urandom);
                if (k == 0) begin s_a = '0; s_b = '0; s_op = 2'b00; end
                if (s_op == 2'b00) begin
                    full = {1'b0, s_a} + {1'b0, ~s_b} + (W+1)'(1);
                    r  = full[W-1:0];
                    mc = full[W];
                    mv = (s_a[W-1] != s_b[W-1]) && (r[W-1] != s_a[W-1]);
                end else if (s_op == 2'b01) begin
                    full = {1'b0, s_a} + {1'b0, s_b};
                    r  = full[W-1:0];
                    mc = full[W];
                    mv = (s_a[W-1] == s_b[W-1]) && (r[W-1] != s_a[W-1]);
                end else if (s_op == 2'b10) begin
                    r = s_a & s_b;
                end else begin
                    r = s_a ^ s_b;
                end
                s_in_valid = 1'b1;
                #1;
                check_eq($sformatf("sweep%0d/in_ready", gi), 64'(s_in_ready), 64'd1);
                s_q.push_back({r, r[W-1], (r == '0), mc, mv});
                @(posedge clk); #1;
                s_in_valid = 1'b0; s_a = W'($urandom); s_b = W'($urandom);
                cyc = 0;
                do begin
                    @(posedge clk); #1;
                    cyc++;
                end while (!s_out_valid && cyc < 40);
                check_eq($sformatf("sweep%0d/latency", gi), 64'(cyc), 64'(NC));
                e = s_q.pop_front();
                check_eq($sformatf("sweep%0d/result", gi), 64'({s_res, s_n, s_z, s_c, s_v}), 64'(e));
                $display("txn sweep%0d #%0d: res=%h nzcv=%b", gi, k, s_res, {s_n, s_z, s_c, s_v});
                s_out_ready = 1'b1;
                @(posedge clk); #1;
                s_out_ready = 1'b0;
            end
            done = 1'b1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = 2'b00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_eq("reset/in_ready", 64'(in_ready), 64'd1);
        check_eq("reset/out_valid", 64'(out_valid), 64'd0);
        check_eq("reset/result", 64'({res, n, z, c, v}), 64'd0);

        start_op("cmp_5_3", 2'b00, 32'd5, 32'd3, {32'd2, 4'b0010});
        wait_result("cmp_5_3", 4);
        consume("cmp_5_3");

        // Stray in_valid during BUSY must be ignored
        start_op("cmp_3_5", 2'b00, 32'd3, 32'd5, {32'hFFFF_FFFE, 4'b1000});
        check_eq("cmp_3_5/busy_hold", 64'({res, n, z, c, v}), 64'({32'd2, 4'b0010}));
        in_valid = 1'b1; a = '0; b = '0; op = 2'b11;
        wait_result("cmp_3_5", 4);
        in_valid = 1'b0;
        consume("cmp_3_5");

        start_op("cmp_min_1", 2'b00, 32'h8000_0000, 32'd1, {32'h7FFF_FFFF, 4'b0011});
        wait_result("cmp_min_1", 4);
        consume("cmp_min_1");

        start_op("cmn_ff_1", 2'b01, 32'hFFFF_FFFF, 32'd1, {32'd0, 4'b0110});
        wait_result("cmn_ff_1", 4);
        consume("cmn_ff_1");

        start_op("tst_f0_0f", 2'b10, 32'h0000_00F0, 32'h0000_000F, {32'd0, 4'b0110});
        wait_result("tst_f0_0f", 4);
        consume("tst_f0_0f");

        // Backpressure, then consume-and-accept on the same edge
        start_op("cmp_9_2", 2'b00, 32'd9, 32'd2, {32'd7, 4'b0010});
        wait_result("cmp_9_2", 4);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check_eq("stall/out_valid", 64'(out_valid), 64'd1);
            check_eq("stall/in_ready", 64'(in_ready), 64'd0);
            check_eq("stall/result", 64'({res, n, z, c, v}), 64'({32'd7, 4'b0010}));
        end
        out_ready = 1'b1;
        start_op("teq_1234", 2'b11, 32'h1234, 32'h1234, {32'd0, 4'b0110});
        wait_result("teq_1234", 4);
        consume("teq_1234");

        // Reset during the second BUSY cycle aborts the operation
        op = 2'b00; a = 32'd7; b = 32'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check_eq("abort/result", 64'({res, n, z, c, v}), 64'd0);
        check_eq("abort/out_valid", 64'(out_valid), 64'd0);
        check_eq("abort/in_ready", 64'(in_ready), 64'd1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            seen = seen | out_valid;
        end
        check_eq("abort/no_out_valid", 64'(seen), 64'd0);
        $display("txn abort: reset mid-BUSY, nzcv=%b", {n, z, c, v});

        start_op("cmp_7_7", 2'b00, 32'd7, 32'd7, {32'd0, 4'b0110});
        wait_result("cmp_7_7", 4);
        consume("cmp_7_7");

        for (int t = 0; t < 5000 && !(g_sweep[0].done && g_sweep[1].done); t++)
            @(posedge clk);
        check_eq("sweep/done", 64'({g_sweep[0].done, g_sweep[1].done}), 64'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
